// File: rtl/imem_loader_pkg.sv
// Shared types for the imem loader: FSM state encoding, header size, bytes-per-instruction helper.
// No logic of its own; latency and backpressure live in the modules that import it.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int HDR_BYTES = 2;

    function automatic int bpi_of(input int iwidth);
        return iwidth / 8;
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational W-bit adder, carry out dropped (wraps modulo 2^W).
// Zero latency; no flow control.
module adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/flip_flop.sv
// Enabled register with async active-low reset to zero.
// One-cycle latency; no flow control.
module flip_flop #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// Packs bytes MSB-first into an IWIDTH word; full pulses with the accept that completes a word.
// Word is visible the cycle after its last byte; accepts a byte whenever accept is high, no stall of its own.
module instr_assembler
    import imem_loader_pkg::*;
#(
    parameter int IWIDTH = 24,
    parameter int BPI    = bpi_of(IWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        din,
    output logic [IWIDTH-1:0] word,
    output logic              full
);

    localparam int CW = (BPI > 1) ? $clog2(BPI) : 1;

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == CW'(BPI - 1));
    assign full    = accept && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            // new bytes enter at the LSB end, so the first byte ends up as the MSB
            word <= (word << 8) | IWIDTH'(din);
            cnt  <= at_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a count-prefixed byte stream into imem at addresses 0..N-1, holding the core in reset meanwhile.
// Write strobe one cycle after an instruction's last byte; byte_ready drops during writes, when idle/done and on abort.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IWIDTH = 24,
    parameter int PWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              abort_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              we_o,
    output logic [PWIDTH-1:0] waddr_o,
    output logic [IWIDTH-1:0] wdata_o,
    output logic              busy_o,
    output logic              hold_o,
    output logic              done_o
);

    localparam int BPI = bpi_of(IWIDTH);
    localparam int NW  = HDR_BYTES * 8;

    state_t            state;
    logic [NW-1:0]     n_cnt;
    logic [PWIDTH-1:0] idx;
    logic [PWIDTH-1:0] idx_inc;
    logic [PWIDTH-1:0] idx_d;
    logic              idx_en;
    logic [IWIDTH-1:0] word;
    logic              full;
    logic [PWIDTH-1:0] addr_q;
    logic [IWIDTH-1:0] data_q;

    logic active;
    logic rx;
    logic xfer;
    logic wr;
    logic begin_load;
    logic kill;
    logic clear;
    logic last_write;

    assign active     = (state inside {HDR_HI, HDR_LO, DATA, WRITE});
    assign rx         = (state inside {HDR_HI, HDR_LO, DATA}) && !abort_i;
    assign xfer       = rx && byte_valid_i;
    assign wr         = (state == WRITE) && !abort_i;
    assign begin_load = load_start_i && !abort_i && ((state == IDLE) || (state == DONE));
    assign kill       = abort_i && active;
    assign clear      = begin_load || kill;
    assign last_write = (idx_inc == PWIDTH'(n_cnt));

    adder #(.W(PWIDTH)) u_idx_add (
        .a   (idx),
        .b   (PWIDTH'(1)),
        .sum (idx_inc)
    );

    assign idx_d  = clear ? '0 : idx_inc;
    assign idx_en = clear || wr;

    flip_flop #(.W(PWIDTH)) u_idx (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (idx_en),
        .d     (idx_d),
        .q     (idx)
    );

    instr_assembler #(.IWIDTH(IWIDTH), .BPI(BPI)) u_asm (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clear  (clear),
        .accept (xfer && (state == DATA)),
        .din    (byte_i),
        .word   (word),
        .full   (full)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            n_cnt  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (wr) begin
                addr_q <= idx;
                data_q <= word;
            end
            case (state)
                IDLE: begin
                    if (begin_load) state <= HDR_HI;
                end
                HDR_HI: begin
                    if (kill) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        n_cnt[NW-1:8] <= byte_i;
                        state         <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (kill) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        n_cnt[7:0] <= byte_i;
                        state      <= ({n_cnt[NW-1:8], byte_i} == '0) ? DONE : DATA;
                    end
                end
                DATA: begin
                    if (kill) state <= IDLE;
                    else if (full) state <= WRITE;
                end
                WRITE: begin
                    if (kill) state <= IDLE;
                    else state <= last_write ? DONE : DATA;
                end
                DONE: begin
                    if (abort_i) state <= IDLE;
                    else if (begin_load) state <= HDR_HI;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // the live index/word show through only on the write cycle; otherwise the last write is held
    assign waddr_o      = wr ? idx  : addr_q;
    assign wdata_o      = wr ? word : data_q;
    assign we_o         = wr;
    assign byte_ready_o = rx;
    assign busy_o       = active;
    assign hold_o       = active;
    assign done_o       = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus hand-written abort/stall/reset sequences.
module tb_imem_loader;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  b;
        logic        rdy;
        logic        we;
        logic        busy;
        logic        done;
        logic [15:0] addr;
        logic [23:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_d;
    logic        byte_ready;
    logic        we;
    logic [15:0] waddr;
    logic [23:0] wdata;
    logic        busy;
    logic        hold;
    logic        done;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [23:0] last_data = '0;
    vec_t        vt [16];
    logic [7:0]  tog [5];

    always #5 clk = ~clk;

    imem_loader #(.IWIDTH(24), .PWIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .load_start_i (load_start),
        .abort_i      (abort),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_d),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .busy_o       (busy),
        .hold_o       (hold),
        .done_o       (done)
    );

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] b,
                                input logic rdy, input logic w, input logic bz, input logic dn,
                                input logic [15:0] a, input logic [23:0] d);
        vec_t x;
        x.st = st; x.v = v; x.b = b;
        x.rdy = rdy; x.we = w; x.busy = bz; x.done = dn; x.addr = a; x.data = d;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive one cycle's inputs mid-cycle and sample outputs away from the rising edge
    task automatic step(input logic st, input logic ab, input logic v, input logic [7:0] b);
        @(negedge clk);
        load_start = st; abort = ab; byte_valid = v; byte_d = b;
        #1;
        if (we === 1'b1) begin
            wr_cnt++;
            last_addr = waddr;
            last_data = wdata;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1'b0, 1'b0, 1'b1, b);
            ok = (byte_ready === 1'b1);
        end
        check("send_accept", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (done === 1'b1) break;
        end
        check("done_reached", done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, byte_ready, 0);
        check({tag, "_we"},    we, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_hold"},  hold, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_d = 8'h00;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // N=2 stream (00 02 AA BB CC 11 22 33) then N=0 stream (00 00)
        vt[0]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 24'h000000);
        vt[1]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 16'h0000, 24'h000000);
        vt[2]  = mk(0, 1, 8'h02, 1, 0, 1, 0, 16'h0000, 24'h000000);
        vt[3]  = mk(0, 1, 8'hAA, 1, 0, 1, 0, 16'h0000, 24'h000000);
        vt[4]  = mk(0, 1, 8'hBB, 1, 0, 1, 0, 16'h0000, 24'h000000);
        vt[5]  = mk(0, 1, 8'hCC, 1, 0, 1, 0, 16'h0000, 24'h000000);
        vt[6]  = mk(0, 1, 8'h11, 0, 1, 1, 0, 16'h0000, 24'hAABBCC);
        vt[7]  = mk(0, 1, 8'h11, 1, 0, 1, 0, 16'h0000, 24'hAABBCC);
        vt[8]  = mk(0, 1, 8'h22, 1, 0, 1, 0, 16'h0000, 24'hAABBCC);
        vt[9]  = mk(0, 1, 8'h33, 1, 0, 1, 0, 16'h0000, 24'hAABBCC);
        vt[10] = mk(0, 0, 8'h00, 0, 1, 1, 0, 16'h0001, 24'h112233);
        vt[11] = mk(0, 0, 8'h00, 0, 0, 0, 1, 16'h0001, 24'h112233);
        vt[12] = mk(1, 0, 8'h00, 0, 0, 0, 1, 16'h0001, 24'h112233);
        vt[13] = mk(0, 1, 8'h00, 1, 0, 1, 0, 16'h0001, 24'h112233);
        vt[14] = mk(0, 1, 8'h00, 1, 0, 1, 0, 16'h0001, 24'h112233);
        vt[15] = mk(0, 0, 8'h00, 0, 0, 0, 1, 16'h0001, 24'h112233);

        for (int i = 0; i < 16; i++) begin
            step(vt[i].st, 1'b0, vt[i].v, vt[i].b);
            check($sformatf("vec%0d_ready", i), byte_ready, vt[i].rdy);
            check($sformatf("vec%0d_we", i),    we,         vt[i].we);
            check($sformatf("vec%0d_busy", i),  busy,       vt[i].busy);
            check($sformatf("vec%0d_hold", i),  hold,       vt[i].busy);
            check($sformatf("vec%0d_done", i),  done,       vt[i].done);
            check($sformatf("vec%0d_waddr", i), waddr,      vt[i].addr);
            check($sformatf("vec%0d_wdata", i), wdata,      vt[i].data);
        end

        // N=1 with a stall cycle before every byte
        tog[0] = 8'h00; tog[1] = 8'h01; tog[2] = 8'hAA; tog[3] = 8'hBB; tog[4] = 8'hCC;
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (i == 4) check("gap_wdata", wdata, 24'h112233);
            send(tog[i]);
        end
        drain();
        check("gap_wr_cnt", wr_cnt, 1);
        check("gap_addr", last_addr, 16'h0000);
        check("gap_data", last_data, 24'hAABBCC);

        // abort while the third byte of instruction 1 is offered
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00); send(8'h02); send(8'hAA); send(8'hBB); send(8'hCC);
        send(8'h11); send(8'h22);
        step(1'b0, 1'b1, 1'b1, 8'h33);
        check("abort_ready", byte_ready, 0);
        check("abort_we", we, 0);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_idle_ready", byte_ready, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h33);
        check("abort_wr_cnt", wr_cnt, 1);
        check("abort_last_addr", last_addr, 16'h0000);
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00); send(8'h01); send(8'hDD); send(8'hEE); send(8'hFF);
        drain();
        check("reload_wr_cnt", wr_cnt, 1);
        check("reload_addr", last_addr, 16'h0000);
        check("reload_data", last_data, 24'hDDEEFF);

        // load_start pulses while busy must be ignored
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h02); send(8'h01); send(8'h02); send(8'h03);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("busy_start_we", we, 1);
        check("busy_start_addr", waddr, 16'h0000);
        check("busy_start_data", wdata, 24'h010203);
        send(8'h04); send(8'h05); send(8'h06);
        drain();
        check("busy_start_wr_cnt", wr_cnt, 2);
        check("busy_start_last_addr", last_addr, 16'h0001);
        check("busy_start_last_data", last_data, 24'h040506);

        // asynchronous reset with 2 of 3 data bytes received
        wr_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
        @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'hCC);
        check("post_reset_wr_cnt", wr_cnt, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_ready", byte_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
